vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source and output stage for the pong display. Generates the
//  PIXEL_H/PIXEL_V scan coordinates that game_engine consumes. Takes back the
//  3-bit PIXEL it returns two cycles later. Drives the VGA pins with HSYNC,
//  VSYNC and blank-gated RGB, all delay-matched to the pixel.
// PARAMETERS
//  H_ACTIVE   800  visible pixels per line
//  H_FP       40   horizontal front porch (clocks)
//  H_SYNC     48   horizontal sync width
//  H_BP       40   horizontal back porch; H_TOTAL = sum = 928
//  V_ACTIVE   480  visible lines per frame
//  V_FP       13   vertical front porch (lines)
//  V_SYNC     3    vertical sync width
//  V_BP       29   vertical back porch; V_TOTAL = sum = 525
//  SYNC_POL   0    sync asserted level (0 = active-low)
//  PIPE_DELAY 2    clocks from PIXEL_H/V change to matching PIXEL valid (>=1)
// PORTS
//  VGA_CLOCK    in   1   pixel clock
//  RESET        in   1   asynchronous, active-high reset
//  PIXEL        in   3   {R,G,B} from game_engine for coord issued PIPE_DELAY ago
//  PIXEL_H      out  11  current horizontal count, 0..H_TOTAL-1
//  PIXEL_V      out  11  current vertical count, 0..V_TOTAL-1
//  ACTIVE       out  1   PIXEL_H<H_ACTIVE && PIXEL_V<V_ACTIVE (undelayed)
//  FRAME_START  out  1   1-clock pulse when counters are (0,0) (undelayed)
//  VGA_HS       out  1   horizontal sync pin
//  VGA_VS       out  1   vertical sync pin
//  VGA_R/G/B    out  1ea colour pins, forced 0 outside active area
// BEHAVIOUR
//  - Reset (async): PIXEL_H=0, PIXEL_V=0, delay lines cleared to inactive and
//    sync-deasserted, VGA_HS=VGA_VS=~SYNC_POL, RGB=0, FRAME_START=0.
//  - h counter +1 per clock. At H_TOTAL-1 it wraps to 0 and v increments.
//  - v wraps to 0 when it is V_TOTAL-1 and h wraps (both wrap on one edge).
//  - PIXEL_H/PIXEL_V are registered counters. ACTIVE and FRAME_START are
//    registered from the next-state values, so they align with PIXEL_H/V.
//  - hs_raw is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//  - vs_raw is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) and
//    changes only on line boundaries.
//  - hs_raw, vs_raw and ACTIVE pass through PIPE_DELAY-stage shift registers.
//  - Output register: VGA_R/G/B = act_d ? PIXEL : 0. VGA_HS/VS take the
//    delayed sync at the same edge, so every pin lags its coordinate by
//    PIPE_DELAY+1 clocks.
//  - Mid-frame reset: everything restarts at (0,0). The first output line
//    after release is blanked for PIPE_DELAY+1 clocks with no sync glitch.
//  - Counter widths are 11 bits. Parameter sums above 2047 are illegal and
//    are caught by an elaboration check ($error in an initial block).
// CONFIGURATION
//  - Macro VGA_TEST_PATTERN_EN adds input TEST_MODE (1 bit).
//  - With the macro, while TEST_MODE=1, PIXEL is ignored. Eight vertical colour
//    bars of width H_ACTIVE/8 are used: bar index = delayed h / (H_ACTIVE/8),
//    colour = index[2:0]. Delayed h is carried in an extra 11-bit shift line.
//  - Without the macro, the port and the extra h delay line are absent and
//    PIXEL always drives RGB.
// STRUCTURE
//  - Package vga_timing_pkg: default timing localparams, H_TOTAL/V_TOTAL,
//    sync-window start/end constants, 3-bit colour constants (BLACK, RED, ...).
//  - Sub-module vga_delay_line (WIDTH, DEPTH): generic reset-able shift
//    register, used for the sync/active bundle and the test-pattern h.
//  - Top holds the counters, window compares and output register.
// TESTING
//  - Reset release, run 928*525 clks -> exactly one FRAME_START per frame,
//    at PIXEL_H=0, PIXEL_V=0.
//  - Count h=839->840 -> VGA_HS falls exactly 3 clks later.
//    It stays low for 48 clks.
//  - Line 493 start -> VGA_VS low 3 clks after h=0,v=493.
//    It returns high after exactly 3*928 clks.
//  - PIXEL held 3'b111 -> RGB=1 only for 800x480 positions, each shifted 3 clks.
//    RGB=0 on h=800..927 and v=480..524.
//  - Assert RESET at h=500,v=200 for 2 clks -> pins idle immediately.
//    Counters resume at (0,0) with no short sync pulse.
//  - With VGA_TEST_PATTERN_EN and TEST_MODE=1 -> RGB=3'b000 on h 0..99.
//    RGB=3'b111 on h 700..799, independent of PIXEL.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, counter/colour types and the sync bundle carried
// through the pipeline of vga_timing_gen.
package vga_timing_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned RGB_W   = 3;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned H_FP_DEF     = 40;
    localparam int unsigned H_SYNC_DEF   = 48;
    localparam int unsigned H_BP_DEF     = 40;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 13;
    localparam int unsigned V_SYNC_DEF   = 3;
    localparam int unsigned V_BP_DEF     = 29;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    localparam bit          SYNC_POL_DEF   = 1'b0;
    localparam int unsigned PIPE_DELAY_DEF = 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    // {R,G,B} colour constants
    localparam rgb_t BLACK   = 3'b000;
    localparam rgb_t BLUE    = 3'b001;
    localparam rgb_t GREEN   = 3'b010;
    localparam rgb_t CYAN    = 3'b011;
    localparam rgb_t RED     = 3'b100;
    localparam rgb_t MAGENTA = 3'b101;
    localparam rgb_t YELLOW  = 3'b110;
    localparam rgb_t WHITE   = 3'b111;

    // Sync/blank bundle delayed alongside the pixel; '0 means idle.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_bundle_t;

    // Half-open window test: start <= pos < stop.
    function automatic logic in_window(input cnt_t pos, input cnt_t start, input cnt_t stop);
        return (pos >= start) && (pos < stop);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-coordinate / pixel-return bus between the timing generator (master)
// and the pixel source (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    cnt_t PIXEL_H;
    cnt_t PIXEL_V;
    logic ACTIVE;
    logic FRAME_START;
    rgb_t PIXEL;

    modport master (
        output PIXEL_H,
        output PIXEL_V,
        output ACTIVE,
        output FRAME_START,
        input  PIXEL
    );

    modport slave (
        input  PIXEL_H,
        input  PIXEL_V,
        input  ACTIVE,
        input  FRAME_START,
        output PIXEL
    );

endinterface

// File: rtl/vga_delay_line.sv
// Generic reset-able shift register: dout is din delayed by DEPTH clocks.
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             VGA_CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned TOT_W = DEPTH * WIDTH;

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_delay_line: DEPTH must be at least 1");
    end

    // Newest sample sits in the low slice, oldest in the high slice.
    logic [TOT_W-1:0] shreg_q;
    logic [TOT_W-1:0] shreg_nxt_c;

    if (DEPTH == 1) begin : g_one
        assign shreg_nxt_c = din;
    end else begin : g_many
        assign shreg_nxt_c = {shreg_q[TOT_W-WIDTH-1:0], din};
    end

    // Shift one stage per clock; reset loads every stage with RST_VAL.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            shreg_q <= {DEPTH{RST_VAL}};
        end else begin
            shreg_q <= shreg_nxt_c;
        end
    end

    assign dout = shreg_q[TOT_W-1 -: WIDTH];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source and VGA output stage for the pong display.
// Issues PIXEL_H/PIXEL_V scan coordinates, takes the pixel colour back
// PIPE_DELAY clocks later and drives sync and blank-gated RGB pins, all
// lagging their coordinate by PIPE_DELAY+1 clocks.
// Optional build macro VGA_TEST_PATTERN_EN adds TEST_MODE, which replaces
// PIXEL with eight vertical colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter bit          SYNC_POL   = SYNC_POL_DEF,
    parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic             VGA_CLOCK,
    input  logic             RESET,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             TEST_MODE,
`endif
    vga_timing_gen_if.master bus,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_R,
    output logic             VGA_G,
    output logic             VGA_B
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam cnt_t V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam cnt_t H_ACT_END = CNT_W'(H_ACTIVE);
    localparam cnt_t V_ACT_END = CNT_W'(V_ACTIVE);
    localparam cnt_t HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam cnt_t HS_STOP   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam cnt_t VS_STOP   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // (0,0) is visible whenever the active area is non-empty, so ACTIVE
    // resets to match the reset coordinates.
    localparam logic ORIGIN_ACTIVE = (H_ACTIVE > 0) && (V_ACTIVE > 0);

    // Elaboration-time range checks on the timing parameters.
    if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
    end
    if (PIPE_DELAY < 1) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be at least 1");
    end

    cnt_t         h_cnt;
    cnt_t         v_cnt;
    cnt_t         h_nxt_c;
    cnt_t         v_nxt_c;
    logic         active_q;
    logic         frame_start_q;
    sync_bundle_t sync_raw_c;
    sync_bundle_t sync_dly;
    rgb_t         pix_sel_c;
    rgb_t         rgb_q;

    // Next raster position: h wraps each line, v wraps on the last line's wrap.
    always_comb begin
        h_nxt_c = h_cnt + CNT_W'(1);
        v_nxt_c = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt_c = '0;
            v_nxt_c = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end
    end

    // Coordinate counters plus ACTIVE/FRAME_START registered from the next position.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            active_q      <= ORIGIN_ACTIVE;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt         <= h_nxt_c;
            v_cnt         <= v_nxt_c;
            active_q      <= (h_nxt_c < H_ACT_END) && (v_nxt_c < V_ACT_END);
            frame_start_q <= (h_nxt_c == '0) && (v_nxt_c == '0);
        end
    end

    assign bus.PIXEL_H     = h_cnt;
    assign bus.PIXEL_V     = v_cnt;
    assign bus.ACTIVE      = active_q;
    assign bus.FRAME_START = frame_start_q;

    // Undelayed sync windows; v only moves at h wrap so vs is line-aligned.
    always_comb begin
        sync_raw_c     = '0;
        sync_raw_c.hs  = in_window(h_cnt, HS_START, HS_STOP);
        sync_raw_c.vs  = in_window(v_cnt, VS_START, VS_STOP);
        sync_raw_c.act = active_q;
    end

    // Match sync/blank to the pixel return latency; resets to idle.
    vga_delay_line #(
        .WIDTH   ($bits(sync_bundle_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL ('0)
    ) u_sync_dly (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
        .din       (sync_raw_c),
        .dout      (sync_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

    cnt_t h_dly;
    rgb_t bar_rgb_c;

    // Horizontal position delayed to line up with the returned pixel.
    vga_delay_line #(
        .WIDTH   (CNT_W),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (CNT_W'(0))
    ) u_h_dly (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
        .din       (h_cnt),
        .dout      (h_dly)
    );

    assign bar_rgb_c = RGB_W'(h_dly / CNT_W'(BAR_W));
    assign pix_sel_c = TEST_MODE ? bar_rgb_c : bus.PIXEL;
`else
    assign pix_sel_c = bus.PIXEL;
`endif

    // Output register: blank-gated colour and polarity-adjusted syncs.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            VGA_HS <= ~SYNC_POL;
            VGA_VS <= ~SYNC_POL;
            rgb_q  <= BLACK;
        end else begin
            VGA_HS <= sync_dly.hs ? SYNC_POL : ~SYNC_POL;
            VGA_VS <= sync_dly.vs ? SYNC_POL : ~SYNC_POL;
            rgb_q  <= sync_dly.act ? pix_sel_c : BLACK;
        end
    end

    assign VGA_R = rgb_q[2];
    assign VGA_G = rgb_q[1];
    assign VGA_B = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-timing instance (full frames fit in the
// run) and a default-timing instance, both checked every clock against a
// coordinate model, plus directed timing and reset checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int ha; int hf; int hs; int ht;
        int va; int vf; int vs; int vt;
    } tcfg_t;

    localparam int S_HA = 80, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VA = 48, S_VF = 3, S_VS = 3, S_VB = 6;
    localparam int S_HT = 96, S_VT = 60, S_FRAME = 5760;
    localparam int LAG  = 3;

    logic VGA_CLOCK;
    logic RESET;
    logic hs_s, vs_s, r_s, g_s, b_s;
    logic hs_d, vs_d, r_d, g_d, b_d;
`ifdef VGA_TEST_PATTERN_EN
    logic test_mode;
`endif

    vga_timing_gen_if bus_s ();
    vga_timing_gen_if bus_d ();

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .SYNC_POL (1'b0), .PIPE_DELAY (2)
    ) u_dut_s (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_MODE (test_mode),
`endif
        .bus       (bus_s),
        .VGA_HS    (hs_s),
        .VGA_VS    (vs_s),
        .VGA_R     (r_s),
        .VGA_G     (g_s),
        .VGA_B     (b_s)
    );

    vga_timing_gen u_dut_d (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_MODE (test_mode),
`endif
        .bus       (bus_d),
        .VGA_HS    (hs_d),
        .VGA_VS    (vs_d),
        .VGA_R     (r_d),
        .VGA_G     (g_d),
        .VGA_B     (b_d)
    );

    initial VGA_CLOCK = 1'b0;
    always #5 VGA_CLOCK = ~VGA_CLOCK;

    int n_assert;
    int n_fail;
    int t;
    int pix_mode;
    tcfg_t cfg_s;
    tcfg_t cfg_d;
    logic [2:0] drv_s_prev;
    logic [2:0] drv_d_prev;
    logic tm_now;
    logic tm_prev;

    // event log, small instance unless suffixed _d
    int fs_cnt, fs_t, fs_h, fs_v;
    int white_cnt, hslow_cnt, vslow_cnt;
    int hs_fall, hs_rise, vs_fall, vs_rise, hs_fall_d, hs_rise_d;
    logic hs_last, vs_last, hs_last_d;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0d): observed %0d, expected %0d", tag, t, obs, exp);
        end
    endtask

    function automatic int mh(input tcfg_t c, input int tt);
        return tt % c.ht;
    endfunction

    function automatic int mv(input tcfg_t c, input int tt);
        return (tt / c.ht) % c.vt;
    endfunction

    function automatic logic [2:0] pat(input int h, input int v);
        return 3'(h + 3 * v + 1);
    endfunction

    // Pixel-source model: colour for the coordinate issued two clocks ago.
    function automatic logic [2:0] engine_pix(input tcfg_t c, input int tt, input int mode);
        if (mode == 0) return 3'b111;
        if (tt < 2) return 3'b000;
        return pat(mh(c, tt - 2), mv(c, tt - 2));
    endfunction

    task automatic check_inst(input string nm, input tcfg_t c, input int tt,
                              input logic [10:0] ph, input logic [10:0] pv,
                              input logic act, input logic fs,
                              input logic hs, input logic vs, input logic [2:0] rgb,
                              input logic [2:0] pix_prev, input logic tmp);
        int cc, hc, vc;
        logic e_hs, e_vs;
        logic [2:0] e_rgb;
        hc = mh(c, tt);
        vc = mv(c, tt);
        check_val({nm, "_pixel_h"}, 32'(ph), 32'(hc));
        check_val({nm, "_pixel_v"}, 32'(pv), 32'(vc));
        check_val({nm, "_active"}, 32'(act), 32'((hc < c.ha && vc < c.va) ? 1 : 0));
        check_val({nm, "_frame_start"}, 32'(fs), 32'((hc == 0 && vc == 0) ? 1 : 0));
        cc = tt - LAG;
        if (cc < 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = 3'b000;
        end else begin
            hc = mh(c, cc);
            vc = mv(c, cc);
            e_hs = !(hc >= c.ha + c.hf && hc < c.ha + c.hf + c.hs);
            e_vs = !(vc >= c.va + c.vf && vc < c.va + c.vf + c.vs);
            if (hc < c.ha && vc < c.va) e_rgb = tmp ? 3'(hc / (c.ha / 8)) : pix_prev;
            else e_rgb = 3'b000;
        end
        check_val({nm, "_vga_hs"}, 32'(hs), 32'(e_hs));
        check_val({nm, "_vga_vs"}, 32'(vs), 32'(e_vs));
        check_val({nm, "_vga_rgb"}, 32'(rgb), 32'(e_rgb));
    endtask

    task automatic drive_next();
        drv_s_prev = engine_pix(cfg_s, t, pix_mode);
        drv_d_prev = engine_pix(cfg_d, t, pix_mode);
        bus_s.PIXEL = drv_s_prev;
        bus_d.PIXEL = drv_d_prev;
        tm_prev = tm_now;
    endtask

    task automatic clear_log();
        fs_cnt = 0; fs_t = -1; fs_h = -1; fs_v = -1;
        white_cnt = 0; hslow_cnt = 0; vslow_cnt = 0;
        hs_fall = -1; hs_rise = -1; vs_fall = -1; vs_rise = -1;
        hs_fall_d = -1; hs_rise_d = -1;
        hs_last = 1'b1; vs_last = 1'b1; hs_last_d = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge VGA_CLOCK);
            t++;
            check_inst("s", cfg_s, t, bus_s.PIXEL_H, bus_s.PIXEL_V, bus_s.ACTIVE,
                       bus_s.FRAME_START, hs_s, vs_s, {r_s, g_s, b_s}, drv_s_prev, tm_prev);
            check_inst("d", cfg_d, t, bus_d.PIXEL_H, bus_d.PIXEL_V, bus_d.ACTIVE,
                       bus_d.FRAME_START, hs_d, vs_d, {r_d, g_d, b_d}, drv_d_prev, tm_prev);
            if (t <= S_FRAME && bus_s.FRAME_START) begin
                fs_cnt++;
                if (fs_t < 0) begin
                    fs_t = t; fs_h = 32'(bus_s.PIXEL_H); fs_v = 32'(bus_s.PIXEL_V);
                end
            end
            if (t >= LAG && t < LAG + S_FRAME) begin
                if ({r_s, g_s, b_s} == 3'b111) white_cnt++;
                if (!hs_s) hslow_cnt++;
                if (!vs_s) vslow_cnt++;
            end
            if (hs_last && !hs_s && hs_fall < 0) hs_fall = t;
            if (!hs_last && hs_s && hs_fall >= 0 && hs_rise < 0) hs_rise = t;
            if (vs_last && !vs_s && vs_fall < 0) vs_fall = t;
            if (!vs_last && vs_s && vs_fall >= 0 && vs_rise < 0) vs_rise = t;
            if (hs_last_d && !hs_d && hs_fall_d < 0) hs_fall_d = t;
            if (!hs_last_d && hs_d && hs_fall_d >= 0 && hs_rise_d < 0) hs_rise_d = t;
            hs_last = hs_s; vs_last = vs_s; hs_last_d = hs_d;
            drive_next();
        end
    endtask

    task automatic check_idle(input string nm, input logic [10:0] ph, input logic [10:0] pv,
                              input logic fs, input logic hs, input logic vs, input logic [2:0] rgb);
        check_val({nm, "_rst_pixel_h"}, 32'(ph), 32'd0);
        check_val({nm, "_rst_pixel_v"}, 32'(pv), 32'd0);
        check_val({nm, "_rst_frame_start"}, 32'(fs), 32'd0);
        check_val({nm, "_rst_vga_hs"}, 32'(hs), 32'd1);
        check_val({nm, "_rst_vga_vs"}, 32'(vs), 32'd1);
        check_val({nm, "_rst_vga_rgb"}, 32'(rgb), 32'd0);
    endtask

    task automatic release_reset();
        RESET = 1'b0;
        t = 0;
        clear_log();
        drive_next();
    endtask

    initial begin
        n_assert = 0; n_fail = 0; t = 0; pix_mode = 0;
        tm_now = 1'b0; tm_prev = 1'b0;
        cfg_s = '{S_HA, S_HF, S_HS, S_HT, S_VA, S_VF, S_VS, S_VT};
        cfg_d = '{800, 40, 48, 928, 480, 13, 3, 525};
        clear_log();
`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        RESET = 1'b1;
        bus_s.PIXEL = 3'b111;
        bus_d.PIXEL = 3'b111;
        drv_s_prev = 3'b111;
        drv_d_prev = 3'b111;
        repeat (3) @(negedge VGA_CLOCK);
        check_idle("s", bus_s.PIXEL_H, bus_s.PIXEL_V, bus_s.FRAME_START, hs_s, vs_s, {r_s, g_s, b_s});
        check_idle("d", bus_d.PIXEL_H, bus_d.PIXEL_V, bus_d.FRAME_START, hs_d, vs_d, {r_d, g_d, b_d});

        // One full reduced frame with PIXEL held white.
        release_reset();
        run_cycles(S_FRAME + LAG);
        check_val("fs_per_frame", 32'(fs_cnt), 32'd1);
        check_val("fs_time", 32'(fs_t), 32'd5760);
        check_val("fs_at_h0", 32'(fs_h), 32'd0);
        check_val("fs_at_v0", 32'(fs_v), 32'd0);
        check_val("white_pixels", 32'(white_cnt), 32'd3840);
        check_val("hs_low_clks", 32'(hslow_cnt), 32'd480);
        check_val("vs_low_clks", 32'(vslow_cnt), 32'd288);
        check_val("hs_fall_t", 32'(hs_fall), 32'd87);
        check_val("hs_rise_t", 32'(hs_rise), 32'd95);
        check_val("vs_fall_t", 32'(vs_fall), 32'd4899);
        check_val("vs_rise_t", 32'(vs_rise), 32'd5187);
        check_val("d_hs_fall_t", 32'(hs_fall_d), 32'd843);
        check_val("d_hs_rise_t", 32'(hs_rise_d), 32'd891);

        // Coordinate-dependent pixels up to (50,20) of the second frame, then mid-frame reset.
        pix_mode = 1;
        run_cycles(7730 - t);
        check_val("pre_rst_pixel_h", 32'(bus_s.PIXEL_H), 32'd50);
        check_val("pre_rst_pixel_v", 32'(bus_s.PIXEL_V), 32'd20);
        check_val("pre_rst_rgb_lit", 32'({r_s, g_s, b_s}), 32'(pat(47, 20)));
        RESET = 1'b1;
        #1;
        check_idle("s_mid", bus_s.PIXEL_H, bus_s.PIXEL_V, bus_s.FRAME_START, hs_s, vs_s, {r_s, g_s, b_s});
        check_idle("d_mid", bus_d.PIXEL_H, bus_d.PIXEL_V, bus_d.FRAME_START, hs_d, vs_d, {r_d, g_d, b_d});
        repeat (2) @(negedge VGA_CLOCK);
        release_reset();
        run_cycles(1000);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars override PIXEL while TEST_MODE is high.
        test_mode = 1'b1;
        tm_now = 1'b1;
        tm_prev = 1'b1;
        run_cycles(2000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
